// File: rtl/data_ram_arb.sv
// Two-master arbiter for a single-port data RAM: round-robin with optional
// bounded lock ownership, combinational grants and registered read return.
module data_ram_arb #(
   parameter int LOCK_MAX = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m1_req,
   input  logic        m0_lock,
   input  logic        m1_lock,
   input  logic        m0_we,
   input  logic        m1_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m1_addr,
   input  logic [3:0]  m0_sel,
   input  logic [3:0]  m1_sel,
   input  logic [31:0] m0_wdata,
   input  logic [31:0] m1_wdata,
   output logic        m0_gnt,
   output logic        m1_gnt,
   output logic        m0_rvalid,
   output logic        m1_rvalid,
   output logic [31:0] m0_rdata,
   output logic [31:0] m1_rdata,
   output logic        ram_ce,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [3:0]  ram_sel,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t     state, state_nxt;
   logic [7:0] hold_cnt, hold_nxt;
   logic       last_gnt, last_nxt;
   logic       arb_gnt0, arb_gnt1;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      if (v >= LOCK_MAX_C)
         return LOCK_MAX_C;
      return v + 8'd1;
   endfunction

   // Grant decision and FSM next state; ram_rdata never enters this cone.
   always_comb begin
      arb_gnt0  = 1'b0;
      arb_gnt1  = 1'b0;
      state_nxt = state;
      hold_nxt  = hold_cnt;
      last_nxt  = last_gnt;
      case (state)
         IDLE: begin
            if (m0_req && (!m1_req || last_gnt))
               arb_gnt0 = 1'b1;
            else if (m1_req)
               arb_gnt1 = 1'b1;
            if (arb_gnt0 && m0_lock) begin
               state_nxt = OWN0;
               hold_nxt  = 8'd1;
            end else if (arb_gnt1 && m1_lock) begin
               state_nxt = OWN1;
               hold_nxt  = 8'd1;
            end
         end
         OWN0: begin
            arb_gnt0 = m0_req;
            if (!m0_req || !m0_lock || sat_inc(hold_cnt) >= LOCK_MAX_C) begin
               state_nxt = IDLE;
               hold_nxt  = 8'd0;
            end else begin
               hold_nxt  = sat_inc(hold_cnt);
            end
         end
         OWN1: begin
            arb_gnt1 = m1_req;
            if (!m1_req || !m1_lock || sat_inc(hold_cnt) >= LOCK_MAX_C) begin
               state_nxt = IDLE;
               hold_nxt  = 8'd0;
            end else begin
               hold_nxt  = sat_inc(hold_cnt);
            end
         end
         default: begin
            state_nxt = IDLE;
            hold_nxt  = 8'd0;
         end
      endcase
      if (arb_gnt0)
         last_nxt = 1'b0;
      else if (arb_gnt1)
         last_nxt = 1'b1;
   end

   // External grants are suppressed while reset is held.
   assign m0_gnt = arb_gnt0 & ~rst;
   assign m1_gnt = arb_gnt1 & ~rst;

   always_comb begin
      ram_ce    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = 32'd0;
      ram_sel   = 4'd0;
      ram_wdata = 32'd0;
      if (m0_gnt) begin
         ram_ce    = 1'b1;
         ram_we    = m0_we;
         ram_addr  = m0_addr;
         ram_sel   = m0_sel;
         ram_wdata = m0_wdata;
      end else if (m1_gnt) begin
         ram_ce    = 1'b1;
         ram_we    = m1_we;
         ram_addr  = m1_addr;
         ram_sel   = m1_sel;
         ram_wdata = m1_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         hold_cnt  <= 8'd0;
         last_gnt  <= 1'b1;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= 32'd0;
         m1_rdata  <= 32'd0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_nxt;
         last_gnt  <= last_nxt;
         m0_rvalid <= arb_gnt0 & ~m0_we;
         m1_rvalid <= arb_gnt1 & ~m1_we;
         if (arb_gnt0 && !m0_we)
            m0_rdata <= ram_rdata;
         if (arb_gnt1 && !m1_we)
            m1_rdata <= ram_rdata;
      end
   end

endmodule
